// File: rtl/byte_assembler.sv
// Serial-to-parallel byte assembler: MSB-first bits qualified by i_svalid,
// framed by i_start, with an idle-cycle timeout that aborts partial bytes.
module byte_assembler #(
    parameter int TIMEOUT = 16
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic       i_sdata,
    input  logic       i_svalid,
    output logic [7:0] o_data,
    output logic       o_load,
    output logic       o_busy,
    output logic       o_err
);
    localparam int IW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [2:0]    bcnt_q, bcnt_d;
    logic [IW-1:0] idle_q, idle_d;
    logic [IW-1:0] idle_inc;
    logic [7:0]    shreg_q, shreg_d;
    logic [7:0]    data_q, data_d;
    logic          err_q, err_d;
    logic [7:0]    shifted;

    assign shifted  = {shreg_q[6:0], i_sdata};
    assign idle_inc = idle_q + IW'(1);

    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        idle_d  = idle_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d = S_SHIFT;
                    bcnt_d  = 3'd0;
                    idle_d  = '0;
                    shreg_d = 8'h00;
                end
            end
            S_SHIFT: begin
                // A start strobe restarts the frame and outranks data and timeout.
                if (i_start) begin
                    bcnt_d  = 3'd0;
                    idle_d  = '0;
                    shreg_d = 8'h00;
                end else if (i_svalid) begin
                    shreg_d = shifted;
                    bcnt_d  = bcnt_q + 3'd1;
                    idle_d  = '0;
                    if (bcnt_q == 3'd7) begin
                        state_d = S_DONE;
                        data_d  = shifted;
                    end
                end else if (idle_inc == IW'(TIMEOUT)) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                    bcnt_d  = 3'd0;
                    idle_d  = '0;
                    shreg_d = 8'h00;
                end else begin
                    idle_d = idle_inc;
                end
            end
            S_DONE: begin
                bcnt_d  = 3'd0;
                idle_d  = '0;
                shreg_d = 8'h00;
                state_d = i_start ? S_SHIFT : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            bcnt_q  <= 3'd0;
            idle_q  <= '0;
            shreg_q <= 8'h00;
            data_q  <= 8'h00;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            idle_q  <= idle_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    assign o_data = data_q;
    assign o_load = (state_q == S_DONE);
    assign o_busy = (state_q == S_SHIFT);
    assign o_err  = err_q;
endmodule

// File: doc/byte_assembler.md
BYTE_ASSEMBLER -- requirements
Module: byte_assembler

Interface
REQ-001 Parameter: TIMEOUT, default 16, number of consecutive idle cycles in SHIFT before a frame is aborted; legal range 2..255.
REQ-002 i_clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 i_start  input  1  frame-start strobe, one cycle; begins a new byte.
REQ-005 i_sdata  input  1  serial data bit, MSB first.
REQ-006 i_svalid  input  1  qualifies i_sdata for the current cycle.
REQ-007 o_data  output  8  last completed byte; feeds the downstream holding register's data input.
REQ-008 o_load  output  1  one-cycle pulse marking o_data as newly updated; drives the downstream register's enable.
REQ-009 o_busy  output  1  high while in SHIFT.
REQ-010 o_err  output  1  one-cycle pulse on timeout abort.

Function
REQ-011 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-012 IDLE: i_start=1 SHALL move to SHIFT, clear the bit counter and clear the idle counter; i_svalid in that same cycle SHALL be ignored.
REQ-013 SHIFT: each cycle with i_svalid=1 SHALL shift i_sdata into the internal shift register LSB-side, increment the 3-bit bit counter and clear the idle counter.
REQ-014 SHIFT: when the 8th valid bit is accepted (counter 7 -> wrap), the FSM SHALL move to DONE and load the assembled byte into o_data on that same edge.
REQ-015 The first accepted bit SHALL end up in o_data[7] and the eighth in o_data[0].
REQ-016 DONE lasts exactly one cycle; o_load SHALL be 1 only in DONE, so o_load rises one cycle after the edge that accepted bit 8.
REQ-017 DONE: the FSM SHALL return to IDLE unless i_start=1, in which case it SHALL go directly to SHIFT (back-to-back frames, no idle cycle required).
REQ-018 DONE: i_svalid SHALL be ignored.
REQ-019 o_data SHALL change only on byte completion; partial bytes are never visible, and o_data holds its value through IDLE, SHIFT, abort and restart.
REQ-020 SHIFT: each cycle with i_svalid=0 SHALL increment the idle counter, which is sized to hold TIMEOUT without overflow.
REQ-021 When the idle counter reaches TIMEOUT, the FSM SHALL go to IDLE, pulse o_err for one cycle and discard the partial byte.
REQ-022 SHIFT: i_start=1 SHALL restart the frame, clearing the bit and idle counters, discarding the partial byte and ignoring the same-cycle i_svalid, with no o_err.
REQ-023 i_start takes priority over i_svalid and over a coincident timeout; on a coincident timeout o_err SHALL NOT pulse.
REQ-024 o_busy SHALL equal (state==SHIFT).
REQ-025 o_load and o_err SHALL never be high in the same cycle.

Reset
REQ-026 While i_rst_n=0, regardless of i_clk: state=IDLE, o_data=8'h00, o_load=0, o_busy=0, o_err=0, all counters and the shift register=0.
REQ-027 Reset asserted mid-frame SHALL discard the partial byte; after release the block SHALL wait in IDLE for i_start.

Verification
REQ-028 Basic frame: i_start, then bits 1,0,1,0,0,1,0,1 on 8 consecutive cycles -> o_data=8'hA5 with o_load=1 for exactly one cycle, one cycle after bit 8.
REQ-029 Gapped frame: byte 8'h3C with 5-cycle gaps between bits (TIMEOUT=16) -> o_data=8'h3C, one o_load pulse, o_err stays 0.
REQ-030 Timeout: i_start, 3 bits, then i_svalid=0 for 16 cycles -> o_err pulse, o_busy=0, o_data keeps previous 8'hA5, no o_load.
REQ-031 Restart: i_start, 4 bits, i_start again, then 8 bits of 8'hFF -> o_data=8'hFF, exactly one o_load pulse, no o_err.
REQ-032 Back-to-back: i_start asserted during DONE of byte 8'h01, then byte 8'h80 -> two o_load pulses, o_data 8'h01 then 8'h80.
REQ-033 Async reset: i_rst_n low between clock edges after bit 5 -> all outputs 0 immediately; 8 bits sent with no i_start afterwards -> no o_load.
